uart_rx_frame_ctrl: RTL and testbench

Sequences the UART receiver and parses its byte stream into length-delimited, checksummed frames.
- Frame format: SYNC 0xA5, LEN, LEN payload bytes, CHK.
- Payload is buffered internally and released on a valid/ready stream only after the checksum passes. Bad or stalled frames are discarded and flagged.
- Sits between the UART receiver (drives its enable, watches its busy/byte outputs) and the packet consumer logic.

---
 rtl/uart_rx_frame_ctrl_if.sv | 18 +
 rtl/uart_rx_frame_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_frame_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_ctrl_if
// Payload stream between the UART frame controller and the packet consumer.
//   data  : payload byte
//   valid : data is valid
//   last  : final payload byte of the frame
//   ready : consumer accepts the byte
// master = frame controller (drives data/valid/last), slave = consumer.
// ---------------------------------------------------------------------------
interface uart_rx_frame_ctrl_if;
   logic [7:0] data;
   logic       valid;
   logic       last;
   logic       ready;

   modport master (output data, output valid, output last, input ready);
   modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_frame_ctrl
// Parses the UART receiver byte stream into frames of the form
//   SYNC_BYTE, LEN, LEN payload bytes, CHK
// where CHK = (LEN + sum of payload) mod 256. Payload is buffered and only
// released on the output stream once the checksum matches; bad, oversize or
// stalled frames are dropped and flagged with a one-cycle pulse.
//
// Ports:
//   clkSys    : system clock
//   rst       : asynchronous active-high reset
//   ctrl_en   : block enable (low returns to HUNT, no error pulses)
//   rx_busy   : receiver busy; its falling edge marks a received byte
//   rx_byte   : receiver data, sampled on the busy falling edge
//   rx_en     : receiver enable
//   out       : payload stream (data/valid/last/ready)
//   frame_ok  : pulse, checksum matched
//   err_chk   : pulse, checksum mismatch
//   err_len   : pulse, LEN is 0 or larger than MAX_LEN
//   err_tmo   : pulse, inter-byte timeout
//   err_ovr   : pulse, byte dropped while draining
//   frame_cnt : good frame count, wraps
// ---------------------------------------------------------------------------
module uart_rx_frame_ctrl #(
   parameter int         MAX_LEN    = 16,
   parameter logic [7:0] SYNC_BYTE  = 8'hA5,
   parameter int         TMO_CYCLES = 400000
) (
   input  logic                 clkSys,
   input  logic                 rst,
   input  logic                 ctrl_en,
   input  logic                 rx_busy,
   input  logic [7:0]           rx_byte,
   output logic                 rx_en,
   uart_rx_frame_ctrl_if.master out,
   output logic                 frame_ok,
   output logic                 err_chk,
   output logic                 err_len,
   output logic                 err_tmo,
   output logic                 err_ovr,
   output logic [15:0]          frame_cnt
);

   localparam int LW = $clog2(MAX_LEN + 1);
   localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam int TW = $clog2(TMO_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYCLES - 1);
   localparam logic [TW-1:0] T_ONE    = TW'(1);
   localparam logic [LW-1:0] L_ONE    = LW'(1);

   typedef enum logic [2:0] {
      S_HUNT,
      S_LEN,
      S_PAYLOAD,
      S_CHK,
      S_DRAIN
   } state_t;

   state_t        state;
   logic          busy_p0;
   logic [LW-1:0] len;
   logic [LW-1:0] wr_idx;
   logic [LW-1:0] rd_idx;
   logic [7:0]    chk_sum;
   logic [TW-1:0] tmo_cnt;
   logic [7:0]    buf_mem [MAX_LEN];

   logic          stb;
   logic          len_ok;
   logic          timed;
   logic          tmo_hit;
   logic [LW-1:0] rd_nxt;

   // Gated by rst so the receiver is held off while the block is in reset.
   assign rx_en   = ctrl_en & ~rst;
   assign stb     = busy_p0 & ~rx_busy;
   assign len_ok  = (rx_byte != 8'd0) && (rx_byte <= 8'(MAX_LEN));
   assign timed   = (state == S_LEN) || (state == S_PAYLOAD) || (state == S_CHK);
   // A byte arriving in the expiry cycle takes priority over the timeout.
   assign tmo_hit = timed && !stb && (tmo_cnt == TMO_LAST);
   assign rd_nxt  = rd_idx + L_ONE;

   // Payload buffer: data only, contents undefined after reset.
   always_ff @(posedge clkSys) begin
      if (ctrl_en && (state == S_PAYLOAD) && stb)
         buf_mem[wr_idx[IW-1:0]] <= rx_byte;
   end

   always_ff @(posedge clkSys or posedge rst) begin
      if (rst) begin
         state     <= S_HUNT;
         busy_p0   <= 1'b0;
         len       <= '0;
         wr_idx    <= '0;
         rd_idx    <= '0;
         chk_sum   <= 8'd0;
         tmo_cnt   <= '0;
         out.data  <= 8'd0;
         out.valid <= 1'b0;
         out.last  <= 1'b0;
         frame_ok  <= 1'b0;
         err_chk   <= 1'b0;
         err_len   <= 1'b0;
         err_tmo   <= 1'b0;
         err_ovr   <= 1'b0;
         frame_cnt <= 16'd0;
      end else begin
         busy_p0  <= rx_busy;
         frame_ok <= 1'b0;
         err_chk  <= 1'b0;
         err_len  <= 1'b0;
         err_tmo  <= 1'b0;
         err_ovr  <= 1'b0;

         // Timeout counter only runs while a frame is being received.
         if (timed && !stb)
            tmo_cnt <= tmo_cnt + T_ONE;
         else
            tmo_cnt <= '0;

         if (!ctrl_en) begin
            state     <= S_HUNT;
            out.valid <= 1'b0;
            out.last  <= 1'b0;
            tmo_cnt   <= '0;
         end else begin
            case (state)
               S_HUNT: begin
                  if (stb && (rx_byte == SYNC_BYTE))
                     state <= S_LEN;
               end

               S_LEN: begin
                  if (stb) begin
                     if (len_ok) begin
                        len     <= rx_byte[LW-1:0];
                        chk_sum <= rx_byte;
                        wr_idx  <= '0;
                        state   <= S_PAYLOAD;
                     end else begin
                        err_len <= 1'b1;
                        state   <= S_HUNT;
                     end
                  end else if (tmo_hit) begin
                     err_tmo <= 1'b1;
                     state   <= S_HUNT;
                  end
               end

               S_PAYLOAD: begin
                  if (stb) begin
                     chk_sum <= chk_sum + rx_byte;
                     wr_idx  <= wr_idx + L_ONE;
                     if (wr_idx == (len - L_ONE))
                        state <= S_CHK;
                  end else if (tmo_hit) begin
                     err_tmo <= 1'b1;
                     state   <= S_HUNT;
                  end
               end

               S_CHK: begin
                  if (stb) begin
                     if (rx_byte == chk_sum) begin
                        frame_ok  <= 1'b1;
                        frame_cnt <= frame_cnt + 16'd1;
                        rd_idx    <= '0;
                        out.data  <= buf_mem[0];
                        out.last  <= (len == L_ONE);
                        out.valid <= 1'b1;
                        state     <= S_DRAIN;
                     end else begin
                        err_chk <= 1'b1;
                        state   <= S_HUNT;
                     end
                  end else if (tmo_hit) begin
                     err_tmo <= 1'b1;
                     state   <= S_HUNT;
                  end
               end

               S_DRAIN: begin
                  // Receiver keeps running while the buffer drains; bytes are lost.
                  if (stb)
                     err_ovr <= 1'b1;
                  if (out.valid && out.ready) begin
                     if (out.last) begin
                        out.valid <= 1'b0;
                        out.last  <= 1'b0;
                        state     <= S_HUNT;
                     end else begin
                        rd_idx   <= rd_nxt;
                        out.data <= buf_mem[rd_nxt[IW-1:0]];
                        out.last <= (rd_nxt == (len - L_ONE));
                     end
                  end
               end

               default: state <= S_HUNT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_frame_ctrl
// Directed bench for uart_rx_frame_ctrl with MAX_LEN=16 and a short timeout
// (TMO_CYCLES=100). Bytes are fed through a modelled receiver busy pulse;
// a negedge monitor counts pulse cycles and records accepted stream bytes.
// ---------------------------------------------------------------------------
module tb_uart_rx_frame_ctrl;

   localparam int MAX_LEN = 16;
   localparam int TMO     = 100;

   logic        clkSys = 1'b0;
   logic        rst;
   logic        ctrl_en;
   logic        rx_busy;
   logic [7:0]  rx_byte;
   logic        rx_en;
   logic        frame_ok;
   logic        err_chk;
   logic        err_len;
   logic        err_tmo;
   logic        err_ovr;
   logic [15:0] frame_cnt;

   uart_rx_frame_ctrl_if oif ();

   uart_rx_frame_ctrl #(
      .MAX_LEN    (MAX_LEN),
      .SYNC_BYTE  (8'hA5),
      .TMO_CYCLES (TMO)
   ) dut (
      .clkSys    (clkSys),
      .rst       (rst),
      .ctrl_en   (ctrl_en),
      .rx_busy   (rx_busy),
      .rx_byte   (rx_byte),
      .rx_en     (rx_en),
      .out       (oif),
      .frame_ok  (frame_ok),
      .err_chk   (err_chk),
      .err_len   (err_len),
      .err_tmo   (err_tmo),
      .err_ovr   (err_ovr),
      .frame_cnt (frame_cnt)
   );

   always #5 clkSys = ~clkSys;

   int vec = 0;
   int err = 0;
   int exp_frames = 0;

   int n_ok = 0;
   int n_chk = 0;
   int n_len = 0;
   int n_tmo = 0;
   int n_ovr = 0;
   int n_vld = 0;
   logic [7:0] s_data [$];
   logic       s_last [$];
   logic [7:0] tx_q [$];

   always @(negedge clkSys) begin
      if (frame_ok) n_ok++;
      if (err_chk)  n_chk++;
      if (err_len)  n_len++;
      if (err_tmo)  n_tmo++;
      if (err_ovr)  n_ovr++;
      if (oif.valid) n_vld++;
      if (oif.valid && oif.ready) begin
         s_data.push_back(oif.data);
         s_last.push_back(oif.last);
      end
   end

   function automatic int pulses();
      return n_ok + n_chk + n_len + n_tmo + n_ovr;
   endfunction

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clkSys);
         #1;
      end
   endtask

   // One receiver byte: busy high for 3 cycles, byte presented as busy falls.
   task automatic send_byte(input logic [7:0] b);
      rx_busy = 1'b1;
      tick(3);
      rx_busy = 1'b0;
      rx_byte = b;
      tick(1);
   endtask

   task automatic send_q();
      foreach (tx_q[i]) send_byte(tx_q[i]);
   endtask

   task automatic wait_stream(input int n, input int budget);
      int k;
      k = 0;
      while (s_data.size() < n && k < budget) begin
         tick(1);
         k++;
      end
      if (s_data.size() < n) begin
         vec++; err++;
         $display("FAIL stream_wait: got %0d bytes, need %0d", s_data.size(), n);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; ctrl_en = 1'b0; rx_busy = 1'b0; rx_byte = 8'h00; oif.ready = 1'b0;
      tick(2);
      vec++;
      if ({frame_ok, err_chk, err_len, err_tmo, err_ovr, oif.valid, oif.last, oif.data, frame_cnt, rx_en} !== 31'd0) begin
         err++;
         $display("FAIL reset_outputs: valid=%b data=%h cnt=%h rx_en=%b, expected all 0", oif.valid, oif.data, frame_cnt, rx_en);
      end
      ctrl_en = 1'b1;
      #1;
      vec++;
      if (rx_en !== 1'b0) begin err++; $display("FAIL reset_rx_en: got %b, expected 0", rx_en); end
      tick(1);
      rst = 1'b0;
      tick(2);
      vec++;
      if (rx_en !== 1'b1) begin err++; $display("FAIL rx_en_on: got %b, expected 1", rx_en); end
   endtask

   task automatic test_good_frame();
      int s0, b_ok, b_p;
      logic [7:0] exp_d [3];
      exp_d = '{8'h11, 8'h22, 8'h33};
      s0 = s_data.size(); b_ok = n_ok; b_p = pulses();
      oif.ready = 1'b1;
      tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
      send_q();
      wait_stream(s0 + 3, 40);
      tick(3);
      exp_frames++;
      vec++;
      if (n_ok - b_ok !== 1) begin err++; $display("FAIL good_frame_ok: got %0d pulses, expected 1", n_ok - b_ok); end
      vec++;
      if (pulses() - b_p !== 1) begin err++; $display("FAIL good_no_err: got %0d pulses total, expected 1", pulses() - b_p); end
      vec++;
      if (frame_cnt !== 16'(exp_frames)) begin err++; $display("FAIL good_cnt: got %0d, expected %0d", frame_cnt, exp_frames); end
      vec++;
      if (s_data.size() !== s0 + 3) begin err++; $display("FAIL good_len: got %0d bytes, expected %0d", s_data.size() - s0, 3); end
      for (int i = 0; i < 3; i++) begin
         vec++;
         if (s_data[s0+i] !== exp_d[i] || s_last[s0+i] !== (i == 2)) begin
            err++;
            $display("FAIL good_byte%0d: got %h last=%b, expected %h last=%b", i, s_data[s0+i], s_last[s0+i], exp_d[i], (i == 2));
         end
      end
   endtask

   task automatic test_bad_chk();
      int s0, b_chk, b_v, b_ok;
      s0 = s_data.size(); b_chk = n_chk; b_v = n_vld; b_ok = n_ok;
      tx_q = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A};
      send_q();
      tick(5);
      vec++;
      if (n_chk - b_chk !== 1) begin err++; $display("FAIL badchk_pulse: got %0d, expected 1", n_chk - b_chk); end
      vec++;
      if (n_vld - b_v !== 0 || n_ok - b_ok !== 0) begin err++; $display("FAIL badchk_quiet: valid cycles %0d ok %0d, expected 0 0", n_vld - b_v, n_ok - b_ok); end
      vec++;
      if (frame_cnt !== 16'(exp_frames)) begin err++; $display("FAIL badchk_cnt: got %0d, expected %0d", frame_cnt, exp_frames); end
      tx_q = '{8'hA5, 8'h01, 8'h5A, 8'h5B};
      send_q();
      wait_stream(s0 + 1, 40);
      tick(2);
      exp_frames++;
      vec++;
      if (s_data[s0] !== 8'h5A || s_last[s0] !== 1'b1 || frame_cnt !== 16'(exp_frames)) begin
         err++;
         $display("FAIL badchk_recover: got %h last=%b cnt=%0d, expected 5a last=1 cnt=%0d", s_data[s0], s_last[s0], frame_cnt, exp_frames);
      end
   endtask

   task automatic test_len_bounds();
      int s0, b_len, b_p, b_ok;
      b_len = n_len;
      tx_q = '{8'hA5, 8'h00};
      send_q(); tick(2);
      vec++;
      if (n_len - b_len !== 1) begin err++; $display("FAIL len_zero: got %0d, expected 1", n_len - b_len); end
      tx_q = '{8'hA5, 8'h11};
      send_q(); tick(2);
      vec++;
      if (n_len - b_len !== 2) begin err++; $display("FAIL len_17: got %0d, expected 2", n_len - b_len); end
      // Rejected LEN of A5 is not treated as a new sync.
      b_ok = n_ok;
      tx_q = '{8'hA5, 8'hA5, 8'h01, 8'h5A, 8'h5B};
      send_q(); tick(3);
      vec++;
      if (n_len - b_len !== 3 || n_ok !== b_ok) begin err++; $display("FAIL len_resync: len %0d ok %0d, expected 3 0", n_len - b_len, n_ok - b_ok); end
      b_p = pulses();
      tx_q = '{8'h00, 8'hFF, 8'h12};
      send_q(); tick(2);
      vec++;
      if (pulses() !== b_p) begin err++; $display("FAIL garbage: got %0d pulses, expected 0", pulses() - b_p); end
      s0 = s_data.size();
      tx_q = '{8'hA5, 8'h10};
      for (int i = 1; i <= 16; i++) tx_q.push_back(8'(i));
      tx_q.push_back(8'h98);
      send_q();
      wait_stream(s0 + 16, 60);
      tick(2);
      exp_frames++;
      vec++;
      if (frame_cnt !== 16'(exp_frames) || s_data.size() !== s0 + 16) begin
         err++;
         $display("FAIL len_max: cnt %0d bytes %0d, expected %0d 16", frame_cnt, s_data.size() - s0, exp_frames);
      end
      for (int i = 0; i < 16; i++) begin
         vec++;
         if (s_data[s0+i] !== 8'(i + 1) || s_last[s0+i] !== (i == 15)) begin
            err++;
            $display("FAIL len_max_byte%0d: got %h last=%b, expected %h last=%b", i, s_data[s0+i], s_last[s0+i], 8'(i + 1), (i == 15));
         end
      end
   endtask

   task automatic test_timeout();
      int b_tmo, b_ok;
      b_tmo = n_tmo;
      tx_q = '{8'hA5, 8'h02, 8'h11};
      send_q();
      tick(TMO - 1);
      vec++;
      if (err_tmo !== 1'b0) begin err++; $display("FAIL tmo_early: got %b, expected 0", err_tmo); end
      tick(1);
      vec++;
      if (err_tmo !== 1'b1) begin err++; $display("FAIL tmo_exact: got %b, expected 1", err_tmo); end
      tick(1);
      vec++;
      if (err_tmo !== 1'b0 || n_tmo - b_tmo !== 1) begin err++; $display("FAIL tmo_width: level %b count %0d, expected 0 1", err_tmo, n_tmo - b_tmo); end
      b_ok = n_ok;
      tx_q = '{8'h22, 8'h35};
      send_q(); tick(3);
      vec++;
      if (n_ok !== b_ok) begin err++; $display("FAIL tmo_hunt: got %0d frame_ok, expected 0", n_ok - b_ok); end
   endtask

   task automatic test_tmo_race();
      int s0, b_tmo, b_ok;
      s0 = s_data.size(); b_tmo = n_tmo; b_ok = n_ok;
      tx_q = '{8'hA5, 8'h02, 8'h11};
      send_q();
      tick(TMO - 4);
      send_byte(8'h22);
      tick(3);
      vec++;
      if (n_tmo !== b_tmo) begin err++; $display("FAIL race_tmo: got %0d err_tmo, expected 0", n_tmo - b_tmo); end
      send_byte(8'h35);
      wait_stream(s0 + 2, 40);
      tick(2);
      exp_frames++;
      vec++;
      if (n_ok - b_ok !== 1 || s_data[s0] !== 8'h11 || s_data[s0+1] !== 8'h22 || s_last[s0+1] !== 1'b1) begin
         err++;
         $display("FAIL race_frame: ok %0d bytes %h %h, expected 1 11 22", n_ok - b_ok, s_data[s0], s_data[s0+1]);
      end
   endtask

   task automatic test_backpressure();
      int s0, b_ovr, bad;
      s0 = s_data.size(); b_ovr = n_ovr; bad = 0;
      oif.ready = 1'b0;
      tx_q = '{8'hA5, 8'h02, 8'hAB, 8'hCD, 8'h7A};
      send_q();
      exp_frames++;
      for (int i = 0; i < 50; i++) begin
         tick(1);
         if (oif.valid !== 1'b1 || oif.data !== 8'hAB || oif.last !== 1'b0) bad++;
      end
      vec++;
      if (bad !== 0) begin err++; $display("FAIL bp_hold: %0d unstable cycles, data %h valid %b, expected ab 1", bad, oif.data, oif.valid); end
      send_byte(8'hA5);
      tick(2);
      vec++;
      if (n_ovr - b_ovr !== 1) begin err++; $display("FAIL ovr_pulse: got %0d, expected 1", n_ovr - b_ovr); end
      vec++;
      if (oif.data !== 8'hAB || oif.valid !== 1'b1) begin err++; $display("FAIL ovr_hold: data %h valid %b, expected ab 1", oif.data, oif.valid); end
      oif.ready = 1'b1;
      wait_stream(s0 + 2, 20);
      tick(2);
      vec++;
      if (s_data.size() !== s0 + 2 || s_data[s0] !== 8'hAB || s_last[s0] !== 1'b0 || s_data[s0+1] !== 8'hCD || s_last[s0+1] !== 1'b1) begin
         err++;
         $display("FAIL bp_stream: %0d bytes %h %h, expected 2 ab cd", s_data.size() - s0, s_data[s0], s_data[s0+1]);
      end
      vec++;
      if (oif.valid !== 1'b0 || frame_cnt !== 16'(exp_frames)) begin err++; $display("FAIL bp_end: valid %b cnt %0d, expected 0 %0d", oif.valid, frame_cnt, exp_frames); end
   endtask

   task automatic test_reset_mid();
      tx_q = '{8'hA5, 8'h03, 8'h11};
      send_q();
      rst = 1'b1;
      #1;
      vec++;
      if ({oif.valid, oif.data, frame_cnt, frame_ok, err_tmo} !== 27'd0) begin
         err++;
         $display("FAIL rst_payload: valid %b data %h cnt %0d, expected 0 0 0", oif.valid, oif.data, frame_cnt);
      end
      tick(2);
      rst = 1'b0;
      exp_frames = 0;
      tick(2);
      oif.ready = 1'b0;
      tx_q = '{8'hA5, 8'h01, 8'h77, 8'h78};
      send_q();
      tick(2);
      vec++;
      if (oif.valid !== 1'b1 || frame_cnt !== 16'd1) begin err++; $display("FAIL rst_pre_drain: valid %b cnt %0d, expected 1 1", oif.valid, frame_cnt); end
      rst = 1'b1;
      #1;
      vec++;
      if (oif.valid !== 1'b0 || frame_cnt !== 16'd0 || oif.last !== 1'b0) begin
         err++;
         $display("FAIL rst_drain: valid %b last %b cnt %0d, expected 0 0 0", oif.valid, oif.last, frame_cnt);
      end
      tick(2);
      rst = 1'b0;
      oif.ready = 1'b1;
      tick(2);
   endtask

   task automatic test_enable();
      int s0, b_p;
      tx_q = '{8'hA5, 8'h03, 8'h11};
      send_q();
      b_p = pulses();
      ctrl_en = 1'b0;
      #1;
      vec++;
      if (rx_en !== 1'b0) begin err++; $display("FAIL en_rx_en: got %b, expected 0", rx_en); end
      tick(3);
      ctrl_en = 1'b1;
      s0 = s_data.size();
      tx_q = '{8'h22, 8'h33, 8'h69};
      send_q(); tick(3);
      vec++;
      if (pulses() !== b_p || s_data.size() !== s0) begin err++; $display("FAIL en_hunt: %0d pulses %0d bytes, expected 0 0", pulses() - b_p, s_data.size() - s0); end
      tx_q = '{8'hA5, 8'h01, 8'h5A, 8'h5B};
      send_q();
      wait_stream(s0 + 1, 40);
      tick(2);
      exp_frames++;
      vec++;
      if (s_data[s0] !== 8'h5A || frame_cnt !== 16'(exp_frames)) begin
         err++;
         $display("FAIL en_recover: got %h cnt %0d, expected 5a %0d", s_data[s0], frame_cnt, exp_frames);
      end
   endtask

   initial begin
      test_reset();
      test_good_frame();
      test_bad_chk();
      test_len_bounds();
      test_timeout();
      test_tmo_race();
      test_backpressure();
      test_reset_mid();
      test_enable();
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

endmodule
